spi_mem_loader: RTL and testbench

Parametrised serial loader that lets an external master write and read back the processor's on-chip memories over a MOSI/MISO bit stream with one active-low chip select per memory. It is the generalised successor of the fixed 12-bit buffer and control-FSM pair that feeds the instruction and data caches. Data width, address width and target count are parametrised, and it adds framed read-back, abort and error detection. It sits between the pad-level uio pins and the cache write/read ports, and is gated by the processor's run state.

---
 rtl/spi_mem_loader_pkg.sv | 30 +++
 rtl/spi_mem_loader_shreg.sv | 37 +++
 rtl/spi_mem_loader.sv | 208 ++++++++++++++++++++
 tb/tb_spi_mem_loader.sv | 361 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_mem_loader_pkg.sv
// +--------------------------------------------------------------------+
// | loader_pkg: state encoding, command codes and counter width helper  |
// | Revision: 1.0                                                       |
// +--------------------------------------------------------------------+
`default_nettype none

package loader_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    ADDR     = 3'd1,
    WDATA    = 3'd2,
    COMMIT   = 3'd3,
    RLOAD    = 3'd4,
    RDATA    = 3'd5,
    WAIT_END = 3'd6
  } state_t;

  localparam logic CMD_WRITE = 1'b1;
  localparam logic CMD_READ  = 1'b0;

  function automatic int cnt_width(input int addr_w, input int data_w);
    int m;
    m = (addr_w > data_w) ? addr_w : data_w;
    return $clog2(m + 1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/spi_mem_loader_shreg.sv
// +--------------------------------------------------------------------+
// | loader_shreg: serial-in / parallel-load shift register, MSB out     |
// | Revision: 1.0                                                       |
// +--------------------------------------------------------------------+
`default_nettype none

module loader_shreg #(
  parameter int WIDTH = 12
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             shift,
  input  logic             sin,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] q,
  output logic             msb
);

  logic [WIDTH-1:0] r_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_q <= '0;
    end else if (load) begin
      r_q <= load_val;
    end else if (shift) begin
      r_q <= {r_q[WIDTH-2:0], sin};
    end
  end

  assign q   = r_q;
  assign msb = r_q[WIDTH-1];

endmodule

`default_nettype wire

// File: rtl/spi_mem_loader.sv
// +--------------------------------------------------------------------+
// | spi_mem_loader: serial write/read-back loader for on-chip memories  |
// | Optional read-back: SPI_LOADER_READBACK_EN. Revision: 1.0           |
// +--------------------------------------------------------------------+
`default_nettype none

module spi_mem_loader #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4,
  parameter int N_CH   = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N_CH-1:0]        cs_n,
  input  logic                   bit_en,
  input  logic                   mosi,
  input  logic                   lock_in,
  output logic [ADDR_W-1:0]      mem_addr,
  output logic [DATA_W-1:0]      mem_wdata,
  output logic [N_CH-1:0]        mem_we,
  output logic [N_CH-1:0]        mem_re,
  input  logic [N_CH*DATA_W-1:0] mem_rdata,
  output logic                   miso,
  output logic                   frame_done,
  output logic                   err
);
  import loader_pkg::*;

  localparam int SR_W   = ADDR_W + DATA_W;
  localparam int CNT_W  = cnt_width(ADDR_W, DATA_W);
  localparam int CH_W   = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam int NLOW_W = $clog2(N_CH + 1);
  localparam logic [CNT_W-1:0] c_addr_last = CNT_W'(ADDR_W - 1);
  localparam logic [CNT_W-1:0] c_data_last = CNT_W'(DATA_W - 1);

  state_t            r_state;
  logic [CNT_W-1:0]  r_cnt;
  logic [CH_W-1:0]   r_ch;
  logic              r_cmd;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic [N_CH-1:0]   r_we;
  logic [N_CH-1:0]   r_re;
  logic              r_done;
  logic              r_err;

  logic [NLOW_W-1:0] w_n_low;
  logic [CH_W-1:0]   w_ch_sel;
  logic              w_one_low;
  logic              w_multi_low;
  logic              w_abort;
  logic              w_shift;
  logic              w_load;
  logic [SR_W-1:0]   w_q;
  logic [SR_W-1:0]   w_load_val;
  logic              w_msb;
  logic [SR_W-1:0]   w_shift_next;
  logic              w_unused;

  always_comb begin
    w_n_low  = '0;
    w_ch_sel = '0;
    for (int k = 0; k < N_CH; k++) begin
      if (!cs_n[k]) begin
        w_n_low  = w_n_low + 1'b1;
        w_ch_sel = CH_W'(k);
      end
    end
  end

  assign w_one_low    = (w_n_low == NLOW_W'(1));
  assign w_multi_low  = (w_n_low > NLOW_W'(1));
  assign w_abort      = cs_n[r_ch];
  assign w_shift_next = {w_q[SR_W-2:0], mosi};

`ifdef SPI_LOADER_READBACK_EN
  logic [DATA_W-1:0] w_rdata_sel;
  assign w_rdata_sel = mem_rdata[r_ch*DATA_W +: DATA_W];
  assign w_shift     = bit_en && !w_abort &&
                       (r_state == ADDR || r_state == WDATA || r_state == RDATA);
  assign w_load      = (r_state == RLOAD) && !w_abort;
  // Read data sits in the top of the register so it leaves through the MSB.
  assign w_load_val  = {w_rdata_sel, {ADDR_W{1'b0}}};
  assign miso        = (r_state == RDATA) && w_msb;
  assign w_unused    = w_q[SR_W-1];
`else
  assign w_shift     = bit_en && !w_abort && (r_state == ADDR || r_state == WDATA);
  assign w_load      = 1'b0;
  assign w_load_val  = '0;
  assign miso        = 1'b0;
  assign w_unused    = ^{w_q[SR_W-1], w_msb, mem_rdata};
`endif

  loader_shreg #(.WIDTH(SR_W)) u_shreg (
    .clk      (clk),
    .rst      (rst),
    .load     (w_load),
    .shift    (w_shift),
    .sin      (mosi),
    .load_val (w_load_val),
    .q        (w_q),
    .msb      (w_msb)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_ch    <= '0;
      r_cmd   <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_we    <= '0;
      r_re    <= '0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_we   <= '0;
      r_re   <= '0;
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (bit_en && !lock_in) begin
            if (w_multi_low) begin
              r_err <= 1'b1;
            end else if (w_one_low) begin
              r_ch    <= w_ch_sel;
              r_cmd   <= mosi;
              r_cnt   <= '0;
              r_state <= ADDR;
            end
          end
        end
        ADDR: begin
          if (w_abort) begin
            r_state <= IDLE;
          end else if (bit_en) begin
            if (r_cnt == c_addr_last) begin
              r_addr <= w_shift_next[ADDR_W-1:0];
              r_cnt  <= '0;
              case (r_cmd)
                CMD_WRITE: r_state <= WDATA;
                CMD_READ: begin
`ifdef SPI_LOADER_READBACK_EN
                  r_re[r_ch] <= 1'b1;
                  r_state    <= RLOAD;
`else
                  r_state    <= WAIT_END;
`endif
                end
                default: r_state <= IDLE;
              endcase
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end
        end
        WDATA: begin
          if (w_abort) begin
            r_state <= IDLE;
          end else if (bit_en) begin
            if (r_cnt == c_data_last) begin
              r_wdata    <= w_shift_next[DATA_W-1:0];
              r_we[r_ch] <= 1'b1;
              r_done     <= 1'b1;
              r_state    <= COMMIT;
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end
        end
        COMMIT: r_state <= WAIT_END;
`ifdef SPI_LOADER_READBACK_EN
        RLOAD: begin
          r_cnt   <= '0;
          r_state <= w_abort ? IDLE : RDATA;
        end
        RDATA: begin
          if (w_abort) begin
            r_state <= IDLE;
          end else if (bit_en) begin
            if (r_cnt == c_data_last) begin
              r_done  <= 1'b1;
              r_state <= WAIT_END;
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end
        end
`endif
        WAIT_END: begin
          if (cs_n[r_ch]) r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign mem_addr   = r_addr;
  assign mem_wdata  = r_wdata;
  assign mem_we     = r_we;
  assign mem_re     = r_re;
  assign frame_done = r_done;
  assign err        = r_err;

endmodule

`default_nettype wire

// File: tb/tb_spi_mem_loader.sv
// +--------------------------------------------------------------------+
// | tb_spi_mem_loader: scoreboard bench for spi_mem_loader              |
// | Revision: 1.0                                                       |
// +--------------------------------------------------------------------+
`default_nettype none

module tb_spi_mem_loader;

  localparam int DW = 8;
  localparam int AW = 4;
  localparam int NC = 2;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [NC-1:0]    cs_n = '1;
  logic             bit_en = 1'b0;
  logic             mosi = 1'b0;
  logic             lock_in = 1'b0;
  logic [NC*DW-1:0] mem_rdata = '0;
  logic [AW-1:0]    mem_addr;
  logic [DW-1:0]    mem_wdata;
  logic [NC-1:0]    mem_we;
  logic [NC-1:0]    mem_re;
  logic             miso;
  logic             frame_done;
  logic             err;

  spi_mem_loader #(.DATA_W(DW), .ADDR_W(AW), .N_CH(NC)) dut (
    .clk        (clk),
    .rst        (rst),
    .cs_n       (cs_n),
    .bit_en     (bit_en),
    .mosi       (mosi),
    .lock_in    (lock_in),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_we     (mem_we),
    .mem_re     (mem_re),
    .mem_rdata  (mem_rdata),
    .miso       (miso),
    .frame_done (frame_done),
    .err        (err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [NC-1:0] we;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic          done;
  } wr_t;

  typedef struct packed {
    logic [NC-1:0] re;
    logic [AW-1:0] addr;
  } rd_t;

  wr_t  exp_wr[$];
  rd_t  exp_rd[$];
  logic exp_miso[$];
  wr_t  mon_w;
  rd_t  mon_r;
  int   total = 0;
  int   bad = 0;
  int   n_done = 0;
  logic mon_on = 1'b0;

  // Every write/read strobe the DUT raises is matched against the next expected one.
  always @(negedge clk) begin
    if (mon_on && !rst) begin
      if (frame_done === 1'b1) n_done++;
      if (mem_we !== '0) begin
        total++;
        if (exp_wr.size() == 0) begin
          bad++;
          $display("FAIL unexpected_write we=%b addr=%h data=%h", mem_we, mem_addr, mem_wdata);
        end else begin
          mon_w = exp_wr.pop_front();
          if ({mem_we, mem_addr, mem_wdata, frame_done} !== mon_w) begin
            bad++;
            $display("FAIL write_strobe got we=%b addr=%h data=%h done=%b want we=%b addr=%h data=%h done=%b",
                     mem_we, mem_addr, mem_wdata, frame_done, mon_w.we, mon_w.addr, mon_w.data, mon_w.done);
          end
        end
      end
      if (mem_re !== '0) begin
        total++;
        if (exp_rd.size() == 0) begin
          bad++;
          $display("FAIL unexpected_read re=%b addr=%h", mem_re, mem_addr);
        end else begin
          mon_r = exp_rd.pop_front();
          if ({mem_re, mem_addr} !== mon_r) begin
            bad++;
            $display("FAIL read_strobe got re=%b addr=%h want re=%b addr=%h",
                     mem_re, mem_addr, mon_r.re, mon_r.addr);
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  task automatic send_bits(input logic [31:0] v, input int n);
    for (int i = n - 1; i >= 0; i--) begin
      @(negedge clk);
      bit_en = 1'b1;
      mosi   = v[i];
      @(negedge clk);
      bit_en = 1'b0;
    end
  endtask

  task automatic end_frame();
    @(negedge clk);
    cs_n = '1;
    repeat (2) @(negedge clk);
  endtask

  task automatic write_frame(input logic [NC-1:0] csn, input logic [AW-1:0] a, input logic [DW-1:0] d);
    exp_wr.push_back('{we: ~csn, addr: a, data: d, done: 1'b1});
    cs_n = csn;
    send_bits({19'd0, 1'b1, a, d}, 1 + AW + DW);
    end_frame();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    total++;
    if ({mem_addr, mem_wdata, mem_we, mem_re, miso, frame_done} !== '0) begin
      bad++;
      $display("FAIL reset_outputs got addr=%h data=%h we=%b re=%b miso=%b done=%b want all 0",
               mem_addr, mem_wdata, mem_we, mem_re, miso, frame_done);
    end
    total++;
    if (err !== 1'b0) begin
      bad++;
      $display("FAIL reset_err got %b want 0", err);
    end
    rst = 1'b0;
    mon_on = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_write();
    cs_n = 2'b10;
    exp_wr.push_back('{we: 2'b01, addr: 4'h5, data: 8'hA7, done: 1'b1});
    send_bits({19'd0, 1'b1, 4'h5, 8'hA7}, 13);
    total++;
    if (mem_we !== 2'b01 || frame_done !== 1'b1) begin
      bad++;
      $display("FAIL commit_timing got we=%b done=%b want we=01 done=1", mem_we, frame_done);
    end
    @(negedge clk);
    total++;
    if (mem_we !== 2'b00 || frame_done !== 1'b0) begin
      bad++;
      $display("FAIL we_one_cycle got we=%b done=%b want 00/0", mem_we, frame_done);
    end
    end_frame();
    total++;
    if (exp_wr.size() != 0) begin
      bad++;
      $display("FAIL write_missing got pending=%0d want 0", exp_wr.size());
    end
  endtask

  task automatic test_back_to_back();
    write_frame(2'b01, 4'hF, 8'hFF);
    write_frame(2'b10, 4'h0, 8'h00);
    write_frame(2'b01, 4'h9, 8'h5A);
    write_frame(2'b10, 4'hA, 8'h81);
    total++;
    if (exp_wr.size() != 0) begin
      bad++;
      $display("FAIL b2b_missing got pending=%0d want 0", exp_wr.size());
    end
  endtask

  task automatic test_read();
    int d0;
    logic [DW-1:0] rd_val;
    logic eb;
    rd_val    = 8'h3C;
    mem_rdata = {rd_val, 8'h55};
    d0 = n_done;
    cs_n = 2'b01;
`ifdef SPI_LOADER_READBACK_EN
    exp_rd.push_back('{re: 2'b10, addr: 4'h2});
    for (int i = DW - 1; i >= 0; i--) exp_miso.push_back(rd_val[i]);
    send_bits({27'd0, 1'b0, 4'h2}, 5);
    total++;
    if (mem_re !== 2'b10) begin
      bad++;
      $display("FAIL re_timing got re=%b want 10", mem_re);
    end
    for (int i = 0; i < DW; i++) begin
      @(negedge clk);
      eb = exp_miso.pop_front();
      total++;
      if (miso !== eb) begin
        bad++;
        $display("FAIL miso_bit%0d got %b want %b", i, miso, eb);
      end
      bit_en = 1'b1;
      mosi   = 1'($urandom_range(0, 1));
      @(negedge clk);
      bit_en = 1'b0;
    end
    total++;
    if (frame_done !== 1'b1 || miso !== 1'b0) begin
      bad++;
      $display("FAIL read_done got done=%b miso=%b want 1/0", frame_done, miso);
    end
    end_frame();
    total++;
    if (n_done != d0 + 1 || exp_rd.size() != 0) begin
      bad++;
      $display("FAIL read_count got done_pulses=%0d pending=%0d want 1/0", n_done - d0, exp_rd.size());
    end
`else
    send_bits({19'd0, 1'b0, 4'h2, 8'hFF}, 13);
    total++;
    if (miso !== 1'b0 || n_done != d0) begin
      bad++;
      $display("FAIL read_disabled got miso=%b done_pulses=%0d want 0/0", miso, n_done - d0);
    end
    end_frame();
    write_frame(2'b01, 4'h2, 8'hC5);
    total++;
    if (exp_wr.size() != 0) begin
      bad++;
      $display("FAIL after_read_write got pending=%0d want 0", exp_wr.size());
    end
`endif
  endtask

  task automatic test_abort();
    int d0;
    d0 = n_done;
    cs_n = 2'b10;
    send_bits({21'd0, 1'b1, 4'h3, 6'b101101}, 11);
    cs_n = 2'b11;
    repeat (3) @(negedge clk);
    total++;
    if (n_done != d0 || mem_we !== 2'b00) begin
      bad++;
      $display("FAIL abort got done_pulses=%0d we=%b want 0/00", n_done - d0, mem_we);
    end
    write_frame(2'b10, 4'hC, 8'h3E);
    total++;
    if (exp_wr.size() != 0) begin
      bad++;
      $display("FAIL after_abort got pending=%0d want 0", exp_wr.size());
    end
  endtask

  task automatic test_lock();
    int d0;
    d0 = n_done;
    lock_in = 1'b1;
    cs_n = 2'b10;
    send_bits({19'd0, 1'b1, 4'h7, 8'h11}, 13);
    end_frame();
    total++;
    if (n_done != d0) begin
      bad++;
      $display("FAIL lock_block got done_pulses=%0d want 0", n_done - d0);
    end
    lock_in = 1'b0;
    exp_wr.push_back('{we: 2'b01, addr: 4'h6, data: 8'hC3, done: 1'b1});
    cs_n = 2'b10;
    send_bits({29'd0, 3'b101}, 3);
    lock_in = 1'b1;
    send_bits({22'd0, 2'b10, 8'hC3}, 10);
    end_frame();
    lock_in = 1'b0;
    total++;
    if (exp_wr.size() != 0) begin
      bad++;
      $display("FAIL lock_midframe got pending=%0d want 0", exp_wr.size());
    end
  endtask

  task automatic test_err();
    cs_n = 2'b00;
    @(negedge clk);
    bit_en = 1'b1;
    mosi   = 1'b1;
    @(negedge clk);
    bit_en = 1'b0;
    total++;
    if (err !== 1'b1) begin
      bad++;
      $display("FAIL err_set got %b want 1", err);
    end
    cs_n = 2'b11;
    repeat (2) @(negedge clk);
    write_frame(2'b10, 4'h1, 8'h81);
    total++;
    if (err !== 1'b1 || exp_wr.size() != 0) begin
      bad++;
      $display("FAIL err_sticky got err=%b pending=%0d want 1/0", err, exp_wr.size());
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    total++;
    if (err !== 1'b0) begin
      bad++;
      $display("FAIL err_clear got %b want 0", err);
    end
  endtask

  task automatic test_reset_mid_frame();
    cs_n = 2'b10;
    send_bits({24'd0, 1'b1, 4'h9, 3'b111}, 8);
    rst = 1'b1;
    @(negedge clk);
    total++;
    if ({mem_addr, mem_wdata, mem_we, mem_re, miso, frame_done, err} !== '0) begin
      bad++;
      $display("FAIL rst_midframe got addr=%h data=%h we=%b re=%b miso=%b done=%b err=%b want all 0",
               mem_addr, mem_wdata, mem_we, mem_re, miso, frame_done, err);
    end
    rst = 1'b0;
    cs_n = 2'b11;
    repeat (2) @(negedge clk);
    write_frame(2'b10, 4'h4, 8'h4D);
    total++;
    if (exp_wr.size() != 0) begin
      bad++;
      $display("FAIL after_rst got pending=%0d want 0", exp_wr.size());
    end
  endtask

  initial begin
    test_reset();
    test_write();
    test_back_to_back();
    test_read();
    test_abort();
    test_lock();
    test_err();
    test_reset_mid_frame();
    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
